// File: rtl/arb_ch_sched.sv
// Channel scheduler for the 16-entry request buffer. It tracks pending requests and
// downstream credits per channel, arbitrates in LRU order and publishes a registered grant.
module arb_ch_sched #(
    parameter int CRD_W    = 3,
    parameter int CRD_INIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_req_val,
    input  logic [1:0] p_req_ch,
    input  logic [3:0] p_ch_enb,
    input  logic [3:0] p_crd_ret,
    output logic       p_arb_val,
    output logic [1:0] p_arb_ch,
    input  logic       p_sel_val,
    input  logic [3:0] p_sel_req_id,
    input  logic       p_pe,
    output logic       p_gnt_val,
    output logic [1:0] p_gnt_ch,
    output logic [3:0] p_gnt_req_id,
    output logic       p_err,
    output logic [1:0] p_err_cause,
    input  logic       p_err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [CRD_W-1:0] CRD_MAX  = {CRD_W{1'b1}};
    localparam logic [CRD_W-1:0] CRD_RST  = CRD_W'(CRD_INIT);
    localparam logic [4:0]       PEND_MAX = 5'd16;
    localparam logic [1:0]       CAUSE_NONE  = 2'd0;
    localparam logic [1:0]       CAUSE_PE    = 2'd1;
    localparam logic [1:0]       CAUSE_NOENT = 2'd2;
    localparam logic [1:0]       CAUSE_OVF   = 2'd3;

    state_e           state_q, state_d;
    logic [4:0]       pend_q [4];
    logic [4:0]       pend_d [4];
    logic [CRD_W-1:0] crd_q  [4];
    logic [CRD_W-1:0] crd_d  [4];
    logic [1:0]       lru_q  [4];
    logic [1:0]       lru_d  [4];
    logic             arb_val_q, arb_val_d;
    logic [1:0]       arb_ch_q, arb_ch_d;
    logic             gnt_val_q, gnt_val_d;
    logic [1:0]       gnt_ch_q, gnt_ch_d;
    logic [3:0]       gnt_id_q, gnt_id_d;
    logic             err_q, err_d;
    logic [1:0]       cause_q, cause_d;

    logic             grant_s;
    logic [3:0]       enq_s;
    logic [3:0]       dec_s;
    logic             ovf_s;
    logic [3:0]       elig_s;
    logic             pick_found_s;
    logic [1:0]       pick_ch_s;
    logic             lru_hit_s;
    logic [1:0]       new_cause_s;

    // Successful select response while the strobe is out
    always_comb begin
        grant_s = (state_q == ST_ISSUE) && p_sel_val && !p_pe;
    end

    // Per-channel increment/decrement requests
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            enq_s[c] = p_req_val && (p_req_ch == 2'(c));
            dec_s[c] = grant_s && (arb_ch_q == 2'(c));
        end
    end

    // Pending and credit counters; simultaneous inc/dec cancel, overflow saturates
    always_comb begin
        ovf_s = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (enq_s[c] && !dec_s[c]) begin
                if (pend_q[c] == PEND_MAX) begin
                    ovf_s     = 1'b1;
                    pend_d[c] = pend_q[c];
                end else begin
                    pend_d[c] = pend_q[c] + 5'd1;
                end
            end else if (!enq_s[c] && dec_s[c]) begin
                pend_d[c] = pend_q[c] - 5'd1;
            end else begin
                pend_d[c] = pend_q[c];
            end

            if (p_crd_ret[c] && !dec_s[c]) begin
                if (crd_q[c] == CRD_MAX) begin
                    ovf_s    = 1'b1;
                    crd_d[c] = crd_q[c];
                end else begin
                    crd_d[c] = crd_q[c] + CRD_W'(1);
                end
            end else if (!p_crd_ret[c] && dec_s[c]) begin
                crd_d[c] = crd_q[c] - CRD_W'(1);
            end else begin
                crd_d[c] = crd_q[c];
            end
        end
    end

    // Eligibility and LRU pick: lru_q[0] is the least recently granted channel
    always_comb begin
        pick_found_s = 1'b0;
        pick_ch_s    = lru_q[0];
        for (int c = 0; c < 4; c++) begin
            elig_s[c] = p_ch_enb[c] && (pend_q[c] != 5'd0) && (crd_q[c] != '0);
        end
        for (int i = 0; i < 4; i++) begin
            if (!pick_found_s && elig_s[lru_q[i]]) begin
                pick_found_s = 1'b1;
                pick_ch_s    = lru_q[i];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Move the granted channel to the MRU end, closing the gap it leaves
    always_comb begin
        lru_hit_s = 1'b0;
        lru_d     = lru_q;
        if (grant_s) begin
            for (int i = 0; i < 3; i++) begin
                if (lru_q[i] == arb_ch_q) begin
                    lru_hit_s = 1'b1;
                end else begin
                    lru_hit_s = lru_hit_s;
                end
                if (lru_hit_s) begin
                    lru_d[i] = lru_q[i + 1];
                end else begin
                    lru_d[i] = lru_q[i];
                end
            end
            lru_d[3] = arb_ch_q;
        end else begin
            lru_d = lru_q;
        end
    end

    // Error source this cycle; a bad select response outranks a concurrent overflow
    always_comb begin
        if ((state_q == ST_ISSUE) && p_pe) begin
            new_cause_s = CAUSE_PE;
        end else if ((state_q == ST_ISSUE) && !p_sel_val) begin
            new_cause_s = CAUSE_NOENT;
        end else if (ovf_s) begin
            new_cause_s = CAUSE_OVF;
        end else begin
            new_cause_s = CAUSE_NONE;
        end
    end

    // Scheduler FSM next state, strobe, grant and sticky error
    always_comb begin
        state_d   = state_q;
        arb_val_d = 1'b0;
        arb_ch_d  = arb_ch_q;
        gnt_val_d = 1'b0;
        gnt_ch_d  = gnt_ch_q;
        gnt_id_d  = gnt_id_q;
        err_d     = err_q;
        cause_d   = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (ovf_s) begin
                    state_d = ST_ERR;
                end else if (pick_found_s) begin
                    arb_val_d = 1'b1;
                    arb_ch_d  = pick_ch_s;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (grant_s) begin
                    gnt_val_d = 1'b1;
                    gnt_ch_d  = arb_ch_q;
                    gnt_id_d  = p_sel_req_id;
                    state_d   = ovf_s ? ST_ERR : ST_GAP;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_GAP: begin
                state_d = ovf_s ? ST_ERR : ST_IDLE;
            end
            ST_ERR: begin
                if (p_err_clr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_ERR) && p_err_clr) begin
            err_d   = 1'b0;
            cause_d = CAUSE_NONE;
        end else if (!err_q && (new_cause_s != CAUSE_NONE)) begin
            err_d   = 1'b1;
            cause_d = new_cause_s;
        end else begin
            err_d   = err_q;
            cause_d = cause_q;
        end
    end

    // State, counters, LRU order and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            arb_val_q <= 1'b0;
            arb_ch_q  <= 2'd0;
            gnt_val_q <= 1'b0;
            gnt_ch_q  <= 2'd0;
            gnt_id_q  <= 4'd0;
            err_q     <= 1'b0;
            cause_q   <= CAUSE_NONE;
            for (int c = 0; c < 4; c++) begin
                pend_q[c] <= 5'd0;
                crd_q[c]  <= CRD_RST;
                lru_q[c]  <= 2'(c);
            end
        end else begin
            state_q   <= state_d;
            arb_val_q <= arb_val_d;
            arb_ch_q  <= arb_ch_d;
            gnt_val_q <= gnt_val_d;
            gnt_ch_q  <= gnt_ch_d;
            gnt_id_q  <= gnt_id_d;
            err_q     <= err_d;
            cause_q   <= cause_d;
            pend_q    <= pend_d;
            crd_q     <= crd_d;
            lru_q     <= lru_d;
        end
    end

    assign p_arb_val    = arb_val_q;
    assign p_arb_ch     = arb_ch_q;
    assign p_gnt_val    = gnt_val_q;
    assign p_gnt_ch     = gnt_ch_q;
    assign p_gnt_req_id = gnt_id_q;
    assign p_err        = err_q;
    assign p_err_cause  = cause_q;

endmodule

// File: tb/tb_arb_ch_sched.sv
// Randomized bench for arb_ch_sched against a queue-based model of the scheduling rules,
// with an emulated request buffer answering the arbitration strobe.
module tb_arb_ch_sched;

    localparam int CRD_INIT = 4;
    localparam int CRD_MAX  = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       p_req_val;
    logic [1:0] p_req_ch;
    logic [3:0] p_ch_enb;
    logic [3:0] p_crd_ret;
    logic       p_arb_val;
    logic [1:0] p_arb_ch;
    logic       p_sel_val;
    logic [3:0] p_sel_req_id;
    logic       p_pe;
    logic       p_gnt_val;
    logic [1:0] p_gnt_ch;
    logic [3:0] p_gnt_req_id;
    logic       p_err;
    logic [1:0] p_err_cause;
    logic       p_err_clr;

    arb_ch_sched #(.CRD_W(3), .CRD_INIT(CRD_INIT)) dut (
        .clk(clk), .rst(rst),
        .p_req_val(p_req_val), .p_req_ch(p_req_ch), .p_ch_enb(p_ch_enb), .p_crd_ret(p_crd_ret),
        .p_arb_val(p_arb_val), .p_arb_ch(p_arb_ch),
        .p_sel_val(p_sel_val), .p_sel_req_id(p_sel_req_id), .p_pe(p_pe),
        .p_gnt_val(p_gnt_val), .p_gnt_ch(p_gnt_ch), .p_gnt_req_id(p_gnt_req_id),
        .p_err(p_err), .p_err_cause(p_err_cause), .p_err_clr(p_err_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    typedef struct {int ch; int id;} ent_t;

    // Reference model: counts, LRU list, buffer contents and expected outputs
    int   m_pend[4];
    int   m_crd[4];
    int   lru[$];
    ent_t buf_q[$];
    int   next_id;
    bit   m_arb, m_gnt, m_err;
    int   m_arb_ch, m_gnt_ch, m_gnt_id, m_cause;

    function automatic int find_ch(input int ch);
        int r = -1;
        for (int k = 0; k < buf_q.size(); k++)
            if (r < 0 && buf_q[k].ch == ch) r = k;
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_pend[c] = 0;
            m_crd[c]  = CRD_INIT;
        end
        lru = '{0, 1, 2, 3};
        buf_q.delete();
        next_id = 0;
        m_arb = 0; m_gnt = 0; m_err = 0;
        m_arb_ch = 0; m_gnt_ch = 0; m_gnt_id = 0; m_cause = 0;
    endtask

    task automatic check_outputs();
        chk("arb_val", p_arb_val, m_arb);
        if (m_arb) chk("arb_ch", p_arb_ch, m_arb_ch);
        chk("gnt_val", p_gnt_val, m_gnt);
        if (m_gnt) begin
            chk("gnt_ch", p_gnt_ch, m_gnt_ch);
            chk("gnt_id", p_gnt_req_id, m_gnt_id);
        end
        chk("err", p_err, m_err);
        chk("err_cause", p_err_cause, m_cause);
    endtask

    // One clock: check, drive the next inputs (buffer answers the strobe), advance model
    task automatic cyc(input bit rv, input int rch, input logic [3:0] enb,
                       input logic [3:0] cret, input bit clr, input bit pe, input bit nosel);
        int  idx, sel_id, pick, np, nc, cause, d, e;
        bit  sel, pe_eff, grant, ovf, idle;
        @(negedge clk);
        check_outputs();
        idx    = m_arb ? find_ch(m_arb_ch) : -1;
        sel    = m_arb && !nosel && (idx >= 0);
        sel_id = (idx >= 0) ? buf_q[idx].id : 0;
        pe_eff = m_arb && pe;
        p_req_val = rv; p_req_ch = 2'(rch); p_ch_enb = enb; p_crd_ret = cret;
        p_err_clr = clr; p_sel_val = sel; p_sel_req_id = sel_id[3:0]; p_pe = pe_eff;

        grant = m_arb && sel && !pe_eff;
        idle  = !m_err && !m_arb && !m_gnt;
        pick  = -1;
        if (idle)
            foreach (lru[k])
                if (pick < 0 && enb[lru[k]] && m_pend[lru[k]] > 0 && m_crd[lru[k]] > 0) pick = lru[k];
        ovf = 0;
        if (grant) begin
            buf_q.delete(idx);
            for (int k = 0; k < lru.size(); k++)
                if (lru[k] == m_arb_ch) begin lru.delete(k); break; end
            lru.push_back(m_arb_ch);
        end
        for (int c = 0; c < 4; c++) begin
            d  = (grant && m_arb_ch == c) ? 1 : 0;
            e  = (rv && rch == c) ? 1 : 0;
            np = m_pend[c] + e - d;
            nc = m_crd[c] + int'(cret[c]) - d;
            if (np > 16) begin ovf = 1; np = 16; end
            else if (e == 1) begin
                buf_q.push_back('{ch: c, id: next_id});
                next_id = (next_id + 1) % 16;
            end
            if (nc > CRD_MAX) begin ovf = 1; nc = CRD_MAX; end
            m_pend[c] = np;
            m_crd[c]  = nc;
        end
        cause = (m_arb && pe_eff) ? 1 : (m_arb && !sel) ? 2 : ovf ? 3 : 0;
        if (m_err && clr) begin m_err = 0; m_cause = 0; end
        else if (!m_err && cause != 0) begin m_err = 1; m_cause = cause; end
        m_gnt = grant;
        if (grant) begin m_gnt_ch = m_arb_ch; m_gnt_id = sel_id; end
        m_arb = idle && !ovf && (pick >= 0);
        if (m_arb) m_arb_ch = pick;
    endtask

    task automatic idle_n(input int n, input logic [3:0] enb);
        for (int k = 0; k < n; k++) cyc(0, 0, enb, 4'h0, 0, 0, 0);
    endtask

    task automatic zero_inputs();
        p_req_val = 0; p_req_ch = 0; p_ch_enb = 0; p_crd_ret = 0;
        p_sel_val = 0; p_sel_req_id = 0; p_pe = 0; p_err_clr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        zero_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_arb(input logic [3:0] enb, input bit pe, input bit nosel);
        for (int k = 0; k < 20 && !m_arb; k++) cyc(0, 0, enb, 4'h0, 0, pe, nosel);
        if (!m_arb) chk("arb_timeout", 0, 1);
    endtask

    initial begin
        zero_inputs();
        do_reset();

        // LRU start: ch0 before ch1, ch1 ids in order
        cyc(1, 1, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 1, 4'h0, 4'h0, 0, 0, 0);
        idle_n(12, 4'hF);

        // Credit exhaustion on ch2, then one credit return
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1, 2, 4'h0, 4'h0, 0, 0, 0);
        idle_n(18, 4'hF);
        cyc(0, 0, 4'hF, 4'b0100, 0, 0, 0);
        idle_n(6, 4'hF);

        // ch0/ch3 ordering across two rounds
        do_reset();
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 3, 4'h0, 4'h0, 0, 0, 0);
        idle_n(8, 4'hF);
        cyc(1, 3, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0);
        idle_n(8, 4'hF);

        // Parity error during ISSUE, then clear and resume
        do_reset();
        cyc(1, 2, 4'h0, 4'h0, 0, 0, 0);
        cyc(1, 2, 4'h0, 4'h0, 0, 0, 0);
        wait_arb(4'hF, 1, 0);
        idle_n(4, 4'hF);
        cyc(0, 0, 4'hF, 4'h0, 1, 0, 0);
        idle_n(8, 4'hF);

        // Missing select response
        do_reset();
        cyc(1, 1, 4'h0, 4'h0, 0, 0, 0);
        wait_arb(4'hF, 0, 1);
        idle_n(3, 4'hF);
        cyc(0, 0, 4'hF, 4'h0, 1, 0, 0);
        idle_n(5, 4'hF);

        // Pending overflow on ch1 with the channel disabled
        do_reset();
        for (int k = 0; k < 17; k++) cyc(1, 1, 4'h0, 4'h0, 0, 0, 0);
        idle_n(3, 4'h0);
        cyc(0, 0, 4'h0, 4'h0, 1, 0, 0);
        idle_n(14, 4'hF);

        // Credit overflow
        do_reset();
        for (int k = 0; k < 4; k++) cyc(0, 0, 4'hF, 4'b1000, 0, 0, 0);
        idle_n(2, 4'hF);
        cyc(0, 0, 4'hF, 4'h0, 1, 0, 0);

        // Asynchronous reset while the strobe is out
        do_reset();
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0);
        wait_arb(4'hF, 0, 0);
        @(posedge clk);
        #2;
        chk("arb_before_rst", p_arb_val, 1);
        rst = 1'b0;
        zero_inputs();
        #1;
        chk("arb_async_rst", p_arb_val, 0);
        chk("gnt_async_rst", p_gnt_val, 0);
        chk("err_async_rst", p_err, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) cyc(1, 0, 4'h0, 4'h0, 0, 0, 0);
        idle_n(18, 4'hF);

        // Random traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic [3:0] enb, cret;
            enb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            for (int c = 0; c < 4; c++) cret[c] = ($urandom_range(0, 5) == 0);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3), enb, cret,
                m_err && ($urandom_range(0, 3) == 0),
                $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
        end
        idle_n(2, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
